piso_mc_serializer: RTL and testbench
=====================================

Name: piso_mc_serializer

Overview:
- Parametrised multi-channel parallel-in/serial-out block for the MSDAP output path; successor to the single-channel 40-bit PISO.
- Accepts one DATA_W-bit word per channel on a load strobe and holds it until the next Frame pulse.
- Then shifts WORD_BITS bits per channel, one bit per Sclk, on CHANNELS independent serial lines.
- Adds a one-deep holding buffer so the next word can load during shifting, selectable bit order, and overrun/underrun flags.

Parameters:
- DATA_W, 40, width of each channel's parallel word.
- WORD_BITS, 16, number of bits serialised per word, taken from bits [WORD_BITS-1:0]; legal range 1..DATA_W.
- CHANNELS, 2, number of parallel channels (stereo default).
- MSB_FIRST, 1, 1 = bit WORD_BITS-1 goes out first; 0 = bit 0 goes out first.

Ports:
- Sclk  in  1  system/serial clock; all logic on rising edge.
- clear_n  in  1  synchronous active-low reset.
- Frame  in  1  frame sync; high for one or more Sclk cycles, sampled on rising edge.
- p2s_enable  in  1  load strobe; data_in valid when high.
- data_in  in  CHANNELS*DATA_W  channel c word at [c*DATA_W +: DATA_W].
- Output  out  CHANNELS  serial bit of channel c on bit c.
- output_ready  out  1  one-cycle pulse while the last bit of a word is on Output.
- busy  out  1  high in ARMED or SHIFT.
- hold_full  out  1  holding buffer occupied.
- overrun  out  1  one-cycle pulse: a load was dropped.
- underrun  out  1  one-cycle pulse: Frame rose while IDLE.

Behaviour:
- Interface: one clock, Sclk; reset clear_n is synchronous and active-low.
- Reset: while clear_n is low at a rising edge:
  - state = IDLE; shift register, holding buffer and bit counter cleared.
  - Output, output_ready, hold_full, overrun and underrun all 0.
  - Reset mid-shift aborts the word; no output_ready is produced.
- States:
  - IDLE: shift register empty; Output = 0.
  - ARMED: word loaded, waiting for Frame; Output = 0.
  - SHIFT: serialising.
- Frame is level-sampled; a rising edge is detected against a registered copy.
- Only the 0->1 transition starts a word.
- IDLE:
  - p2s_enable=1 loads data_in into the shift register -> ARMED. Frame in the same cycle is not honoured.
  - Frame rising edge with no load -> underrun pulse; stay IDLE.
- ARMED:
  - Frame rising edge -> SHIFT. At that same edge Output[c] takes the first bit of channel c, and bit_cnt = 1.
- SHIFT:
  - Each following edge drives the next bit; bit_cnt increments.
  - The edge that drives bit index WORD_BITS-1 (count WORD_BITS) also drives output_ready = 1 for that cycle.
  - At the next edge Output returns to 0. Next state is ARMED if a word is available (holding buffer or a simultaneous load); otherwise IDLE.
  - Frame rising edges during SHIFT are ignored; there is no restart.
- Total serial length is exactly WORD_BITS cycles. First bit appears 0 cycles after the sampled Frame edge. The next word can shift no earlier than the Frame edge following the return to ARMED.
- Load rules (p2s_enable=1 while busy):
  - hold empty -> capture into holding buffer; hold_full = 1.
  - hold full -> overrun pulse; the new word is dropped and the held word is kept.
  - Completion cycle with hold full -> held word moves to the shift register and the new word enters hold. No overrun.
  - Completion cycle with hold empty -> new word goes straight to the shift register -> ARMED.
- Bit order per MSB_FIRST:
  - 1: bit k uses index WORD_BITS-1-k.
  - 0: bit k uses index k.
  - Bits above WORD_BITS-1 are ignored.
- All channels share one counter and state; they are bit-aligned.
- bit_cnt width = $clog2(WORD_BITS+1). There is no wrap-around beyond WORD_BITS.

Decomposition:
- Shared package msdap_pkg: state enum (IDLE/ARMED/SHIFT), the localparam for counter width, and the default DATA_W = 40.
- One natural sub-module, piso_lane: a per-channel shift/hold datapath with load, transfer and bit-select, instantiated CHANNELS times by generate.
- The control FSM, counter and flags stay in the top level.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles mid-shift -> Output=2'b00 and all flags 0 next cycle; no output_ready.
- Basic, CHANNELS=2, WORD_BITS=16, MSB_FIRST=1: load ch0=0x0000_00A5C3, ch1=0x0000_00FF00, then Frame rise.
  - Output[0] emits 1010010111000011 on 16 consecutive edges; Output[1] emits 1111111100000000.
  - output_ready high only on the 16th bit; Output=0 the cycle after; state IDLE.
- LSB-first: MSB_FIRST=0, load ch0=0x0001 -> first bit 1, remaining 15 bits 0.
- Double buffer: load W1, Frame, then load W2 at bit 5 -> hold_full=1; after W1 completes, state ARMED. The next Frame shifts W2 exactly.
- Overrun: load W1, load W2 during SHIFT, load W3 at bit 8 -> overrun pulse 1 cycle; W2 (not W3) is serialised next.
  - Load coinciding with the completion cycle while hold is full -> no overrun.
- Underrun/ignored Frame: Frame rise in IDLE -> underrun pulse; Frame re-rise at bit 4 of SHIFT -> no restart, still 16 bits total.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared types and defaults for the MSDAP serial output path.
// Holds the controller state encoding and the bit-counter sizing rule.
package msdap_pkg;

    localparam int DATA_W_DEF    = 40;
    localparam int WORD_BITS_DEF = 16;
    localparam int CNT_W_DEF     = $clog2(WORD_BITS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Counter must reach WORD_BITS itself, which marks the completion cycle.
    function automatic int cnt_w(input int word_bits);
        return $clog2(word_bits + 1);
    endfunction

endpackage

// File: rtl/piso_lane.sv
// Per-channel datapath: shift word, one-deep holding word, registered serial bit.
// Latency: serial bit appears one Sclk after drive is asserted.
// Backpressure: none; load/transfer decisions are made by the controller.
import msdap_pkg::*;

module piso_lane #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              Sclk,
    input  logic              clear_n,
    input  logic              ld_sr,
    input  logic              ld_hold,
    input  logic              xfer,
    input  logic              drive,
    input  logic [IDX_W-1:0]  bit_idx,
    input  logic [DATA_W-1:0] data,
    output logic              ser
);

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] hold;

    // ld_sr and xfer are mutually exclusive; ld_hold may coincide with xfer.
    always_ff @(posedge Sclk) begin
        if (!clear_n) begin
            sr   <= '0;
            hold <= '0;
            ser  <= 1'b0;
        end else begin
            if (ld_sr) begin
                sr <= data;
            end else if (xfer) begin
                sr <= hold;
            end
            if (ld_hold) begin
                hold <= data;
            end
            ser <= drive ? sr[bit_idx] : 1'b0;
        end
    end

endmodule

// File: rtl/piso_mc_serializer.sv
// Multi-channel PISO: loads one word per channel, shifts WORD_BITS bits per Frame rise.
// Latency: first bit on Output at the Sclk edge that samples the Frame rise.
// Backpressure: one-deep hold buffer; a load with hold full is dropped and flagged overrun.
import msdap_pkg::*;

module piso_mc_serializer #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int CHANNELS  = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         Sclk,
    input  logic                         clear_n,
    input  logic                         Frame,
    input  logic                         p2s_enable,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic [CHANNELS-1:0]          Output,
    output logic                         output_ready,
    output logic                         busy,
    output logic                         hold_full,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int CNT_W = cnt_w(WORD_BITS);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] WB_C    = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt, cnt_nx;
    logic             frame_q;
    logic             frame_rise;
    logic             done;
    logic             hold_full_nx, ready_nx, over_nx, under_nx;
    logic             ld_sr, ld_hold, xfer, drive;
    logic [CNT_W-1:0] bit_k, idx_cnt;
    logic [IDX_W-1:0] bit_idx;

    assign frame_rise = Frame & ~frame_q;
    assign done       = (state == SHIFT) && (bit_cnt == WB_C);
    assign busy       = (state != IDLE);

    // The bit being driven this edge: index 0 on the Frame edge, else the count so far.
    always_comb begin
        bit_k = (state == SHIFT) ? bit_cnt : '0;
        if (MSB_FIRST) begin
            idx_cnt = WB_LAST - bit_k;
        end else begin
            idx_cnt = bit_k;
        end
        bit_idx = IDX_W'(idx_cnt);
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = bit_cnt;
        hold_full_nx = hold_full;
        ready_nx     = 1'b0;
        over_nx      = 1'b0;
        under_nx     = 1'b0;
        ld_sr        = 1'b0;
        ld_hold      = 1'b0;
        xfer         = 1'b0;
        drive        = 1'b0;

        if (p2s_enable && busy && !done) begin
            if (!hold_full) begin
                ld_hold      = 1'b1;
                hold_full_nx = 1'b1;
            end else begin
                over_nx = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (p2s_enable) begin
                    ld_sr    = 1'b1;
                    state_nx = ARMED;
                end else if (frame_rise) begin
                    under_nx = 1'b1;
                end
            end
            ARMED: begin
                if (frame_rise) begin
                    state_nx = SHIFT;
                    drive    = 1'b1;
                    cnt_nx   = CNT_ONE;
                    ready_nx = (WB_C == CNT_ONE);
                end
            end
            SHIFT: begin
                if (!done) begin
                    drive    = 1'b1;
                    cnt_nx   = bit_cnt + CNT_ONE;
                    ready_nx = (bit_cnt == WB_LAST);
                end else begin
                    cnt_nx   = '0;
                    state_nx = ARMED;
                    // Completion: held word advances, a simultaneous load refills hold.
                    if (hold_full) begin
                        xfer = 1'b1;
                        if (p2s_enable) begin
                            ld_hold = 1'b1;
                        end else begin
                            hold_full_nx = 1'b0;
                        end
                    end else if (p2s_enable) begin
                        ld_sr = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Sclk) begin
        if (!clear_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            frame_q      <= 1'b0;
            hold_full    <= 1'b0;
            output_ready <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nx;
            bit_cnt      <= cnt_nx;
            frame_q      <= Frame;
            hold_full    <= hold_full_nx;
            output_ready <= ready_nx;
            overrun      <= over_nx;
            underrun     <= under_nx;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        piso_lane #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_lane (
            .Sclk    (Sclk),
            .clear_n (clear_n),
            .ld_sr   (ld_sr),
            .ld_hold (ld_hold),
            .xfer    (xfer),
            .drive   (drive),
            .bit_idx (bit_idx),
            .data    (data_in[c*DATA_W +: DATA_W]),
            .ser     (Output[c])
        );
    end

endmodule

// File: tb/tb_piso_mc_serializer.sv
// Bench for piso_mc_serializer: MSB-first and LSB-first instances share stimulus.
// A queue-based word model is checked every cycle, plus literal serial-stream expectations.
module tb_piso_mc_serializer;

    localparam int DW = 40;
    localparam int WB = 16;
    localparam int CH = 2;

    logic          Sclk = 1'b0;
    logic          clear_n = 1'b0;
    logic          Frame = 1'b0;
    logic          p2s_enable = 1'b0;
    logic [CH*DW-1:0] data_in = '0;

    logic [CH-1:0] out_m, out_l;
    logic rdy_m, rdy_l, busy_m, busy_l, hf_m, hf_l, ov_m, ov_l, un_m, un_l;

    int n_chk = 0;
    int n_fail = 0;

    piso_mc_serializer #(.DATA_W(DW), .WORD_BITS(WB), .CHANNELS(CH), .MSB_FIRST(1'b1)) dut (
        .Sclk(Sclk), .clear_n(clear_n), .Frame(Frame), .p2s_enable(p2s_enable),
        .data_in(data_in), .Output(out_m), .output_ready(rdy_m), .busy(busy_m),
        .hold_full(hf_m), .overrun(ov_m), .underrun(un_m)
    );

    piso_mc_serializer #(.DATA_W(DW), .WORD_BITS(WB), .CHANNELS(CH), .MSB_FIRST(1'b0)) dut_l (
        .Sclk(Sclk), .clear_n(clear_n), .Frame(Frame), .p2s_enable(p2s_enable),
        .data_in(data_in), .Output(out_l), .output_ready(rdy_l), .busy(busy_l),
        .hold_full(hf_l), .overrun(ov_l), .underrun(un_l)
    );

    always #5 Sclk = ~Sclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level model: mq[0] is the word armed/being shifted, mq[1] the held one.
    logic [CH*DW-1:0] mq[$];
    bit               m_shift = 1'b0;
    int               m_pos = 0;
    logic             m_fprev = 1'b0;
    logic [CH-1:0]    e_out_m, e_out_l;
    logic             e_rdy, e_busy, e_hf, e_ov, e_un;

    function automatic logic [CH-1:0] pick(input logic [CH*DW-1:0] w, input int k, input bit msb);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c] = w[c*DW + (msb ? (WB - 1 - k) : k)];
        end
        return r;
    endfunction

    task automatic model_step();
        logic rise;
        e_out_m = '0;
        e_out_l = '0;
        e_rdy = 1'b0;
        e_ov = 1'b0;
        e_un = 1'b0;
        if (!clear_n) begin
            mq.delete();
            m_shift = 1'b0;
            m_pos = 0;
            m_fprev = 1'b0;
        end else begin
            rise = Frame && !m_fprev;
            m_fprev = Frame;
            if (mq.size() == 0) begin
                if (p2s_enable) mq.push_back(data_in);
                else if (rise) e_un = 1'b1;
            end else if (m_shift && m_pos == WB) begin
                void'(mq.pop_front());
                m_shift = 1'b0;
                m_pos = 0;
                if (p2s_enable) mq.push_back(data_in);
            end else begin
                if (p2s_enable) begin
                    if (mq.size() < 2) mq.push_back(data_in);
                    else e_ov = 1'b1;
                end
                if (!m_shift && rise) begin
                    m_shift = 1'b1;
                    m_pos = 0;
                end
                if (m_shift) begin
                    e_out_m = pick(mq[0], m_pos, 1'b1);
                    e_out_l = pick(mq[0], m_pos, 1'b0);
                    m_pos++;
                    e_rdy = (m_pos == WB);
                end
            end
        end
        e_busy = (mq.size() > 0);
        e_hf = (mq.size() == 2);
    endtask

    initial begin
        forever begin
            @(posedge Sclk);
            model_step();
            #1;
            chk("out_msb", out_m, e_out_m);
            chk("out_lsb", out_l, e_out_l);
            chk("ready", rdy_m, e_rdy);
            chk("ready_l", rdy_l, e_rdy);
            chk("busy", busy_m, e_busy);
            chk("busy_l", busy_l, e_busy);
            chk("hold_full", hf_m, e_hf);
            chk("hold_full_l", hf_l, e_hf);
            chk("overrun", ov_m, e_ov);
            chk("overrun_l", ov_l, e_ov);
            chk("underrun", un_m, e_un);
            chk("underrun_l", un_l, e_un);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Sclk);
            #2;
        end
    endtask

    task automatic load(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        p2s_enable = 1'b1;
        data_in = {w1, w0};
        tick();
        p2s_enable = 1'b0;
        data_in = '0;
    endtask

    task automatic capture(output logic [WB-1:0] s0, output logic [WB-1:0] s1,
                           output logic [WB-1:0] l0, output logic [WB-1:0] l1,
                           output logic [WB-1:0] rv);
        s0 = '0; s1 = '0; l0 = '0; l1 = '0; rv = '0;
        Frame = 1'b1;
        for (int i = 0; i < WB; i++) begin
            @(posedge Sclk);
            #1;
            s0 = {s0[WB-2:0], out_m[0]};
            s1 = {s1[WB-2:0], out_m[1]};
            l0 = {l0[WB-2:0], out_l[0]};
            l1 = {l1[WB-2:0], out_l[1]};
            rv = {rv[WB-2:0], rdy_m};
            #1;
            Frame = 1'b0;
        end
    endtask

    logic [WB-1:0] s0, s1, l0, l1, rv;

    initial begin
        clear_n = 1'b0;
        tick(3);
        clear_n = 1'b1;
        tick(2);

        // Basic stereo word
        load(40'h00_0000_A5C3, 40'h00_0000_FF00);
        tick(2);
        capture(s0, s1, l0, l1, rv);
        chk("basic_ch0_msb", s0, 16'hA5C3);
        chk("basic_ch1_msb", s1, 16'hFF00);
        chk("basic_ch0_lsb", l0, 16'hC3A5);
        chk("basic_ch1_lsb", l1, 16'h00FF);
        chk("basic_ready_last_only", rv, 16'h0001);
        tick();
        chk("basic_out_zero_after", out_m, 2'b00);
        chk("basic_idle_after", busy_m, 1'b0);
        tick(2);

        // Bit order, with junk above WORD_BITS that must be ignored
        load(40'h55_AAAA_0001, 40'hFF_0000_8000);
        tick();
        capture(s0, s1, l0, l1, rv);
        chk("lsb_ch0_first_bit", l0, 16'h8000);
        chk("lsb_ch1", l1, 16'h0001);
        chk("msb_ch0", s0, 16'h0001);
        chk("msb_ch1", s1, 16'h8000);
        tick(2);

        // Frame rise while idle
        Frame = 1'b1;
        @(posedge Sclk);
        #1;
        chk("underrun_pulse", un_m, 1'b1);
        #1;
        Frame = 1'b0;
        tick(2);

        // Double buffer, plus a Frame re-rise mid-word that must be ignored
        load(40'h00_0000_1234, 40'h00_0000_ABCD);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick(2);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        load(40'h00_0000_0F0F, 40'h00_0000_F00F);
        chk("dbuf_hold_full", hf_m, 1'b1);
        tick(12);
        chk("dbuf_armed_after", busy_m, 1'b1);
        chk("dbuf_hold_empty_after", hf_m, 1'b0);
        tick(2);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick(18);

        // Overrun, then a load on the completion cycle with hold full
        load(40'h00_0000_1111, 40'h00_0000_2222);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick();
        load(40'h00_0000_C001, 40'h00_0000_C002);
        tick(4);
        p2s_enable = 1'b1;
        data_in = {40'h00_0000_DEAD, 40'h00_0000_BEEF};
        @(posedge Sclk);
        #1;
        chk("overrun_pulse", ov_m, 1'b1);
        #1;
        p2s_enable = 1'b0;
        tick(8);
        p2s_enable = 1'b1;
        data_in = {40'h00_0000_0440, 40'h00_0000_0330};
        @(posedge Sclk);
        #1;
        chk("complete_load_no_overrun", ov_m, 1'b0);
        chk("complete_load_hold_full", hf_m, 1'b1);
        #1;
        p2s_enable = 1'b0;
        tick();
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick(17);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick(18);

        // Reset mid-shift with a held word
        load(40'h00_0000_7777, 40'h00_0000_6666);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        tick(2);
        load(40'h00_0000_5555, 40'h00_0000_4444);
        tick();
        clear_n = 1'b0;
        tick(2);
        chk("rst_output", out_m, 2'b00);
        chk("rst_ready", rdy_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_hold", hf_m, 1'b0);
        clear_n = 1'b1;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
